// File: rtl/pipe_lane_reg_if.sv
// Group handshake bundle between two pipeline stages: upstream offer, downstream
// drain, squash controls and the stall counter readout.
interface pipe_lane_reg_if #(
    parameter int unsigned LANES  = 2,
    parameter int unsigned DATA_W = 128
);
    logic [LANES-1:0]        in_valid;
    logic [LANES*DATA_W-1:0] in_data;
    logic                    in_ready;
    logic [LANES-1:0]        out_valid;
    logic [LANES*DATA_W-1:0] out_data;
    logic                    out_ready;
    logic                    flush;
    logic [LANES-1:0]        kill_lane;
    logic                    clr_cnt;
    logic [31:0]             stall_cycles;

    modport slave (
        input  in_valid, in_data, out_ready, flush, kill_lane, clr_cnt,
        output in_ready, out_valid, out_data, stall_cycles
    );

    modport master (
        output in_valid, in_data, out_ready, flush, kill_lane, clr_cnt,
        input  in_ready, out_valid, out_data, stall_cycles
    );
endinterface

// File: rtl/pipe_lane_reg.sv
// Multi-lane in-order pipeline register: groups move together under valid/ready,
// with optional skid entry, flush, younger-lane squash and a saturating stall counter.
module pipe_lane_reg #(
    parameter int unsigned LANES  = 2,
    parameter int unsigned DATA_W = 128,
    parameter int unsigned SKID   = 1
) (
    input logic            clk,
    input logic            resetn,
    pipe_lane_reg_if.slave bus
);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_FULL,
        ST_SKIDFULL
    } state_t;

    typedef logic [LANES-1:0][DATA_W-1:0] lanes_t;

    state_t           r_state;
    logic [LANES-1:0] r_main_vld;
    lanes_t           r_main_data;
    logic [LANES-1:0] r_skid_vld;
    lanes_t           r_skid_data;
    logic [31:0]      r_stall_cnt;

    lanes_t           w_in_data;
    lanes_t           w_km_data;
    logic [LANES-1:0] w_kill_mask;
    logic [LANES-1:0] w_km_vld;
    logic             w_acc;
    logic             w_in_ready;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_kill_act;
    logic             w_main_dead;

    // With the skid entry, ready comes straight from state so it does not
    // combinationally depend on out_ready.
    assign w_in_ready  = (SKID != 0) ? (r_state != ST_SKIDFULL)
                                     : (~r_main_vld[0] | bus.out_ready);
    assign w_in_fire   = bus.in_valid[0] & w_in_ready;
    assign w_out_fire  = r_main_vld[0] & bus.out_ready;
    assign w_kill_act  = (|bus.kill_lane) & ~bus.flush & ~w_out_fire;
    assign w_km_vld    = r_main_vld & ~w_kill_mask;
    assign w_main_dead = w_kill_act & ~w_km_vld[0];

    always_comb begin
        w_in_data   = '0;
        w_km_data   = '0;
        w_kill_mask = '0;
        w_acc       = 1'b0;
        for (int unsigned j = 0; j < LANES; j++) begin
            w_acc          = w_acc | bus.kill_lane[j];
            w_kill_mask[j] = w_acc;
            w_in_data[j]   = bus.in_valid[j] ? bus.in_data[j*DATA_W +: DATA_W] : '0;
            w_km_data[j]   = w_acc ? '0 : r_main_data[j];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_EMPTY;
            r_main_vld  <= '0;
            r_main_data <= '0;
            r_skid_vld  <= '0;
            r_skid_data <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (bus.clr_cnt) begin
                r_stall_cnt <= '0;
            end else if (r_main_vld[0] & ~bus.out_ready & ~(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end

            if (bus.flush) begin
                r_state     <= ST_EMPTY;
                r_main_vld  <= '0;
                r_main_data <= '0;
                r_skid_vld  <= '0;
                r_skid_data <= '0;
            end else if (SKID != 0) begin
                case (r_state)
                    ST_EMPTY: begin
                        if (w_in_fire) begin
                            r_main_vld  <= bus.in_valid;
                            r_main_data <= w_in_data;
                            r_state     <= ST_FULL;
                        end
                    end
                    ST_FULL: begin
                        // A fully killed main entry frees the slot just like a drain.
                        if (w_out_fire | w_main_dead) begin
                            if (w_in_fire) begin
                                r_main_vld  <= bus.in_valid;
                                r_main_data <= w_in_data;
                            end else begin
                                r_main_vld <= '0;
                                if (w_main_dead) begin
                                    r_main_data <= w_km_data;
                                end
                                r_state <= ST_EMPTY;
                            end
                        end else begin
                            if (w_kill_act) begin
                                r_main_vld  <= w_km_vld;
                                r_main_data <= w_km_data;
                            end
                            if (w_in_fire) begin
                                r_skid_vld  <= bus.in_valid;
                                r_skid_data <= w_in_data;
                                r_state     <= ST_SKIDFULL;
                            end
                        end
                    end
                    ST_SKIDFULL: begin
                        if (w_out_fire | w_main_dead) begin
                            r_main_vld  <= r_skid_vld;
                            r_main_data <= r_skid_data;
                            r_skid_vld  <= '0;
                            r_skid_data <= '0;
                            r_state     <= ST_FULL;
                        end else if (w_kill_act) begin
                            r_main_vld  <= w_km_vld;
                            r_main_data <= w_km_data;
                        end
                    end
                    default: begin
                        r_state <= ST_EMPTY;
                    end
                endcase
            end else begin
                if (w_in_fire) begin
                    r_main_vld  <= bus.in_valid;
                    r_main_data <= w_in_data;
                    r_state     <= ST_FULL;
                end else if (w_out_fire) begin
                    r_main_vld <= '0;
                    r_state    <= ST_EMPTY;
                end else if (w_kill_act) begin
                    r_main_vld  <= w_km_vld;
                    r_main_data <= w_km_data;
                    if (!w_km_vld[0]) begin
                        r_state <= ST_EMPTY;
                    end
                end
            end
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = r_main_vld;
    assign bus.out_data     = r_main_data;
    assign bus.stall_cycles = r_stall_cnt;

endmodule

// File: tb/tb_pipe_lane_reg.sv
// Bench for pipe_lane_reg: a FIFO-view model of both a SKID=1 and a SKID=0 instance,
// checked every cycle, plus directed literal checks.
module tb_pipe_lane_reg;
    localparam int unsigned DW = 128;

    typedef struct packed {
        logic [1:0]   vld;
        logic [255:0] data;
    } grp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]   iv[2];
    logic [255:0] id[2];
    logic         ordy[2];
    logic         fl[2];
    logic         clr[2];
    logic [1:0]   kl[2];
    logic         irdy[2];
    logic [1:0]   ov[2];
    logic [255:0] od[2];
    logic [31:0]  sc[2];

    pipe_lane_reg_if #(.LANES(2), .DATA_W(DW)) b0 ();
    pipe_lane_reg_if #(.LANES(2), .DATA_W(DW)) b1 ();

    assign b0.in_valid  = iv[0];
    assign b0.in_data   = id[0];
    assign b0.out_ready = ordy[0];
    assign b0.flush     = fl[0];
    assign b0.clr_cnt   = clr[0];
    assign b0.kill_lane = kl[0];
    assign irdy[0]      = b0.in_ready;
    assign ov[0]        = b0.out_valid;
    assign od[0]        = b0.out_data;
    assign sc[0]        = b0.stall_cycles;

    assign b1.in_valid  = iv[1];
    assign b1.in_data   = id[1];
    assign b1.out_ready = ordy[1];
    assign b1.flush     = fl[1];
    assign b1.clr_cnt   = clr[1];
    assign b1.kill_lane = kl[1];
    assign irdy[1]      = b1.in_ready;
    assign ov[1]        = b1.out_valid;
    assign od[1]        = b1.out_data;
    assign sc[1]        = b1.stall_cycles;

    pipe_lane_reg #(.LANES(2), .DATA_W(DW), .SKID(0)) dut0 (
        .clk(clk), .resetn(resetn), .bus(b0)
    );
    pipe_lane_reg #(.LANES(2), .DATA_W(DW), .SKID(1)) dut1 (
        .clk(clk), .resetn(resetn), .bus(b1)
    );

    // Model: each stage is a FIFO of groups with capacity 2 (SKID=1) or 1 (SKID=0).
    grp_t        mq[2][2];
    int          mn[2];
    logic [31:0] mcnt[2];
    int          n_cmp = 0;
    int          n_fail = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic grp_t mk(input logic [1:0] v, input logic [255:0] d);
        grp_t g;
        g.vld  = v;
        g.data = d;
        if (!v[0]) g.data[127:0] = '0;
        if (!v[1]) g.data[255:128] = '0;
        return g;
    endfunction

    function automatic grp_t squash(input grp_t g, input logic [1:0] k);
        grp_t r;
        int   low;
        r   = g;
        low = k[0] ? 0 : 1;
        for (int j = low; j < 2; j++) begin
            r.vld[j] = 1'b0;
            r.data[j*128 +: 128] = '0;
        end
        return r;
    endfunction

    function automatic logic exp_rdy(input int d);
        if (d == 1) return mn[1] < 2;
        return (mn[0] == 0) || ordy[0];
    endfunction

    task automatic pop(input int d);
        mq[d][0] = mq[d][1];
        mn[d]    = mn[d] - 1;
    endtask

    task automatic step(input int d);
        logic inf, outf;
        inf  = iv[d][0] && exp_rdy(d);
        outf = (mn[d] > 0) && ordy[d];
        if (iv[d][0] && (((iv[d] + 2'd1) & iv[d]) != 2'd0))
            $error("non-thermometer in_valid %b on instance %0d", iv[d], d);
        if (clr[d]) mcnt[d] = '0;
        else if (mn[d] > 0 && !ordy[d] && mcnt[d] != 32'hFFFF_FFFF) mcnt[d] = mcnt[d] + 1;
        if (fl[d]) begin
            mn[d] = 0;
        end else begin
            if (outf) begin
                pop(d);
            end else if (kl[d] != 2'b00 && mn[d] > 0) begin
                mq[d][0] = squash(mq[d][0], kl[d]);
                if (!mq[d][0].vld[0]) pop(d);
            end
            if (inf) begin
                mq[d][mn[d]] = mk(iv[d], id[d]);
                mn[d] = mn[d] + 1;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge resetn);
        if (!resetn) begin
            for (int d = 0; d < 2; d++) begin
                mn[d]   = 0;
                mcnt[d] = '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) step(d);
        end
    end

    initial forever begin
        @(negedge clk);
        if (resetn) begin
            for (int d = 0; d < 2; d++) begin
                logic [1:0] ev;
                ev = (mn[d] > 0) ? mq[d][0].vld : 2'b00;
                chk($sformatf("in_ready%0d", d), 256'(irdy[d]), 256'(exp_rdy(d)));
                chk($sformatf("out_valid%0d", d), 256'(ov[d]), 256'(ev));
                if (ev[0]) chk($sformatf("out_data%0d", d), od[d], mq[d][0].data);
                chk($sformatf("stall%0d", d), 256'(sc[d]), 256'(mcnt[d]));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input int d, input logic [1:0] v, input logic [127:0] l1, input logic [127:0] l0);
        iv[d] = v;
        id[d] = {l1, l0};
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            iv[d] = '0; id[d] = '0; ordy[d] = 1'b0;
            fl[d] = 1'b0; clr[d] = 1'b0; kl[d] = '0;
            mn[d] = 0; mcnt[d] = '0;
        end
        resetn = 1'b0;
        cyc();
        cyc();
        for (int d = 0; d < 2; d++) begin
            chk("rst_in_ready", 256'(irdy[d]), 256'(1));
            chk("rst_out_valid", 256'(ov[d]), 256'(0));
            chk("rst_out_data", od[d], 256'(0));
            chk("rst_stall", 256'(sc[d]), 256'(0));
        end
        resetn = 1'b1;

        // Streaming, out_ready held high
        ordy[1] = 1'b1;
        offer(1, 2'b11, 128'h22, 128'h11);
        cyc();
        offer(1, 2'b01, 128'hDEAD, 128'h33);
        #1;
        chk("strA_valid", 256'(ov[1]), 256'(2'b11));
        chk("strA_data", od[1], {128'h22, 128'h11});
        chk("strA_ready", 256'(irdy[1]), 256'(1));
        cyc();
        iv[1] = 2'b00;
        #1;
        chk("strB_valid", 256'(ov[1]), 256'(2'b01));
        chk("strB_data", od[1], {128'h0, 128'h33});
        chk("strB_stall", 256'(sc[1]), 256'(0));
        cyc();

        // Backpressure into the skid entry
        ordy[1] = 1'b0;
        offer(1, 2'b11, 128'hA1, 128'hA0);
        cyc();
        offer(1, 2'b11, 128'hB1, 128'hB0);
        #1;
        chk("bp_ready_full", 256'(irdy[1]), 256'(1));
        cyc();
        offer(1, 2'b01, 128'h0, 128'hC0);
        #1;
        chk("bp_ready_skid", 256'(irdy[1]), 256'(0));
        chk("bp_main_A", od[1], {128'hA1, 128'hA0});
        chk("bp_stall1", 256'(sc[1]), 256'(1));
        cyc();
        chk("bp_stall2", 256'(sc[1]), 256'(2));
        cyc();
        chk("bp_stall3", 256'(sc[1]), 256'(3));
        ordy[1] = 1'b1;
        cyc();
        #1;
        chk("drain_B", od[1], {128'hB1, 128'hB0});
        chk("drain_ready", 256'(irdy[1]), 256'(1));
        cyc();
        iv[1] = 2'b00;
        #1;
        chk("drain_C_valid", 256'(ov[1]), 256'(2'b01));
        chk("drain_C_data", od[1], {128'h0, 128'hC0});
        cyc();
        chk("drain_empty", 256'(ov[1]), 256'(0));

        // Partial kill of lane 1
        ordy[1] = 1'b0;
        offer(1, 2'b11, 128'hD1, 128'hD0);
        cyc();
        iv[1] = 2'b00;
        kl[1] = 2'b10;
        cyc();
        kl[1] = 2'b00;
        #1;
        chk("pkill_valid", 256'(ov[1]), 256'(2'b01));
        chk("pkill_data", od[1], {128'h0, 128'hD0});

        // Full kill promotes the skid entry
        offer(1, 2'b11, 128'hE1, 128'hE0);
        cyc();
        iv[1] = 2'b00;
        #1;
        chk("fkill_pre_ready", 256'(irdy[1]), 256'(0));
        kl[1] = 2'b01;
        cyc();
        kl[1] = 2'b00;
        #1;
        chk("fkill_valid", 256'(ov[1]), 256'(2'b11));
        chk("fkill_data", od[1], {128'hE1, 128'hE0});
        chk("fkill_ready", 256'(irdy[1]), 256'(1));

        // Flush from SKIDFULL with a group offered, together with clr_cnt
        offer(1, 2'b11, 128'hF1, 128'hF0);
        cyc();
        offer(1, 2'b11, 128'h98, 128'h99);
        fl[1]  = 1'b1;
        clr[1] = 1'b1;
        #1;
        chk("flush_ready_same", 256'(irdy[1]), 256'(0));
        cyc();
        fl[1] = 1'b0; clr[1] = 1'b0; iv[1] = 2'b00;
        #1;
        chk("flush_valid", 256'(ov[1]), 256'(0));
        chk("flush_data", od[1], 256'(0));
        chk("flush_ready", 256'(irdy[1]), 256'(1));
        chk("flush_clr", 256'(sc[1]), 256'(0));
        offer(1, 2'b11, 128'h5A, 128'hA5);
        fl[1] = 1'b1;
        #1;
        chk("flush_empty_ready", 256'(irdy[1]), 256'(1));
        cyc();
        fl[1] = 1'b0; iv[1] = 2'b00;
        ordy[1] = 1'b1;
        #1;
        chk("flush_drop", 256'(ov[1]), 256'(0));
        cyc();
        cyc();

        // SKID=0: combinational in_ready
        offer(0, 2'b11, 128'h52, 128'h51);
        #1;
        chk("s0_ready_empty", 256'(irdy[0]), 256'(1));
        cyc();
        offer(0, 2'b01, 128'h0, 128'h61);
        #1;
        chk("s0_ready_blocked", 256'(irdy[0]), 256'(0));
        chk("s0_main_P", od[0], {128'h52, 128'h51});
        ordy[0] = 1'b1;
        #1;
        chk("s0_ready_comb", 256'(irdy[0]), 256'(1));
        cyc();
        iv[0] = 2'b00;
        #1;
        chk("s0_Q_valid", 256'(ov[0]), 256'(2'b01));
        chk("s0_Q_data", od[0], {128'h0, 128'h61});
        cyc();
        chk("s0_empty", 256'(ov[0]), 256'(0));

        // Stall counter saturation
        ordy[1] = 1'b0;
        offer(1, 2'b01, 128'h0, 128'h77);
        cyc();
        iv[1] = 2'b00;
        force dut1.r_stall_cnt = 32'hFFFF_FFFE;
        mcnt[1] = 32'hFFFF_FFFE;
        #1;
        release dut1.r_stall_cnt;
        cyc();
        chk("sat_first", 256'(sc[1]), 256'(32'hFFFF_FFFF));
        cyc();
        cyc();
        chk("sat_hold", 256'(sc[1]), 256'(32'hFFFF_FFFF));

        // Asynchronous reset between clock edges
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_valid", 256'(ov[1]), 256'(0));
        chk("arst_data", od[1], 256'(0));
        chk("arst_stall", 256'(sc[1]), 256'(0));
        chk("arst_ready", 256'(irdy[1]), 256'(1));
        cyc();
        resetn = 1'b1;
        cyc();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_lane_reg.md
Name: pipe_lane_reg

Overview:
Parametrised multi-lane in-order pipeline register for the dual-issue core. It replaces per-lane enable/clear stage registers with a valid/ready group handshake. The lane count and payload width are parameters, and an optional skid buffer breaks the combinational ready path. It supports a global flush, a partial squash of a lane and all younger lanes, and a saturating stall counter. It sits between adjacent stages (D->E, E->M).

Parameters:
LANES, 2, issue lanes; lane 0 is oldest (master).
DATA_W, 128, payload bits per lane (opaque control and data bundle).
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.

Ports:
clk  in  1  clock, rising edge.
resetn  in  1  asynchronous active-low reset.
in_valid  in  LANES  per-lane valid from the upstream stage; must be thermometer (bit i set implies bit i-1 set).
in_data  in  LANES*DATA_W  lane i occupies bits [i*DATA_W +: DATA_W].
in_ready  out  1  stage accepts a group this cycle.
out_valid  out  LANES  per-lane valid of the main entry.
out_data  out  LANES*DATA_W  main-entry payload.
out_ready  in  1  downstream takes the main entry.
flush  in  1  discard everything held and offered.
kill_lane  in  LANES  squash lane k and all younger lanes of the main entry, where k is the lowest set bit.
clr_cnt  in  1  clear the stall counter.
stall_cycles  out  32  saturating count of held cycles.

Behaviour:
- Reset (resetn=0, async): all out_valid=0, out_data=0, skid entry invalid and zero, stall_cycles=0, in_ready=1. State is EMPTY.
- Group semantics: all lanes of a group move together.
  - in_fire = in_valid[0] & in_ready.
  - out_fire = out_valid[0] & out_ready.
  - in_valid[0]=0 means no group is offered. Upper bits are ignored and no capture occurs.
- SKID=1 states (main, skid):
  - EMPTY: in_fire -> main := input; go to FULL.
  - FULL, out_fire & in_fire: main := input; stay FULL.
  - FULL, out_fire only: go to EMPTY.
  - FULL, in_fire only: skid := input; go to SKIDFULL.
  - SKIDFULL, out_fire: main := skid; go to FULL. in_ready=0 in this state, so there is no capture.
  - in_ready = (state != SKIDFULL), decoded from state flops only.
- SKID=0: single entry; in_ready = ~out_valid[0] | out_ready, combinational. On in_fire, main := input.
- Latency: a group captured at edge N appears on out_* after edge N, i.e. one cycle. A skidded group appears one cycle after the blocking cycle ends.
- flush (highest priority, synchronous):
  - At the edge, main and skid valids are cleared and their data zeroed.
  - The input offered that cycle is dropped; state goes to EMPTY.
  - in_ready is unaffected in the flush cycle.
- kill_lane (ignored if flush=1; ignored if out_fire=1, since the downstream squashes itself in that case):
  - Let k = index of the lowest set bit. At the edge, out_valid[j]:=0 and lane j data:=0 for all j>=k.
  - If this leaves main with no valid lane, main counts as empty at that edge:
    - SKIDFULL: skid moves to main; go to FULL.
    - FULL with in_fire: the input goes to main.
    - Otherwise go to EMPTY.
  - kill_lane never affects the skid entry.
- A thermometer in_valid is preserved. Lanes invalid on input are captured with their data zeroed.
- stall_cycles:
  - Increments on each cycle with out_valid[0] & ~out_ready.
  - Saturates at 32'hFFFF_FFFF.
  - clr_cnt has priority and sets it to 0 at the edge.
  - Flush does not clear it.
- Simultaneous flush & clr_cnt: both take effect.
- Reset asserted mid-transfer clears state immediately, without waiting for clk.
- Assertion (bench only): a non-thermometer in_valid while in_valid[0]=1 is an error.

Test Plan:
- Reset then stream: LANES=2, SKID=1, out_ready=1. Groups A=(valid 2'b11, data 0x11/0x22) and B=(2'b01, 0x33) on back-to-back cycles -> out A on cycle 1, out B on cycle 2 with out_valid=2'b01 and lane 1 data=0; in_ready stays 1; stall_cycles=0.
- Backpressure/skid:
  - Hold out_ready=0 while offering A, B, C -> A in main, B in skid, in_ready=0, C held upstream; stall_cycles counts 1,2,3.
  - Release out_ready -> outputs A, B, C on consecutive cycles; in_ready returns to 1 one cycle after A leaves.
- Partial kill: main holds 2'b11 with out_ready=0; pulse kill_lane=2'b10 -> out_valid=2'b01, lane 1 data=0, lane 0 data unchanged.
- Full kill promotes skid: state SKIDFULL (main A, skid B), kill_lane=2'b01 -> next cycle out shows B and in_ready=1.
- Flush vs. input: SKIDFULL plus in_valid=2'b11, flush=1 -> next cycle out_valid=0, out_data=0, in_ready=1, and the offered group is never output.
- SKID=0 mode and async reset:
  - out_ready=0 with main full -> in_ready=0 combinationally; out_ready=1 in the same cycle -> in_ready=1 and passthrough capture.
  - Drop resetn between clocks -> outputs zero immediately.
  - Force stall_cycles to 32'hFFFF_FFFE and stall 3 cycles -> it saturates at 32'hFFFF_FFFF.
